mem_access_ctrl: RTL and testbench

// - Sequences data-memory accesses for the MEM stage of the pipelined CPU; it sits after the EX/MEM pipeline register.
// - Converts the latched MEM controls (size, sign-extend, rw, enable) into a req/ack transaction on a word-wide data RAM.
// - Asserts stall to hold the EX/MEM register and upstream stages until the access completes.
// - Returns load data that is byte-selected and extended, and flags misaligned and timed-out accesses.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// access-size encodings, controller states and byte-lane helpers.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Big-endian byte enables: offset 0 is bits 31:24, i.e. be[3].
   function automatic logic [3:0] lane_be(input mem_size_e size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         MEM_BYTE: be = 4'b1000 >> off;
         MEM_HALF: be = off[1] ? 4'b0011 : 4'b1100;
         MEM_WORD: be = 4'b1111;
         default:  be = 4'b0000;
      endcase
      return be;
   endfunction

   // Natural alignment; the reserved size is never legal.
   function automatic logic is_aligned(input mem_size_e size, input logic [1:0] off);
      logic ok;
      case (size)
         MEM_BYTE: ok = 1'b1;
         MEM_HALF: ok = ~off[0];
         MEM_WORD: ok = (off == 2'b00);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-wide data RAM bus: the controller is the master, the RAM the slave.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [3:0]        dm_be;
   logic [31:0]       dm_wdata;
   logic              dm_ack;
   logic [31:0]       dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: replicates store data into every lane
// group of its size, and extracts/extends the addressed bytes of a load word.
module mem_lane_align
   import mem_pkg::*;
(
   input  mem_size_e   st_size,
   input  logic [31:0] st_wdata,
   output logic [31:0] lane_wdata,
   input  mem_size_e   ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_se,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store placement: right-justified data copied into every lane group.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      lane_wdata = st_wdata;
      case (st_size)
         MEM_BYTE: lane_wdata = {4{st_wdata[7:0]}};
         MEM_HALF: lane_wdata = {2{st_wdata[15:0]}};
         default:  lane_wdata = st_wdata;
      endcase
   end

   // Load extraction: pick the big-endian byte/half, then sign- or zero-extend.
   always_comb begin
      ld_byte = ld_rdata[7:0];
      case (ld_off)
         2'd0:    ld_byte = ld_rdata[31:24];
         2'd1:    ld_byte = ld_rdata[23:16];
         2'd2:    ld_byte = ld_rdata[15:8];
         default: ld_byte = ld_rdata[7:0];
      endcase
      ld_half = ld_off[1] ? ld_rdata[15:0] : ld_rdata[31:16];
      case (ld_size)
         MEM_BYTE: ld_data = {{24{ld_se & ld_byte[7]}}, ld_byte};
         MEM_HALF: ld_data = {{16{ld_se & ld_half[15]}}, ld_half};
         default:  ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer. Turns the EX/MEM access controls into a
// req/ack transaction on the data RAM, stalls the pipeline until it ends,
// and reports misaligned and timed-out accesses.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_enable,
   input  logic              mem_rw,
   input  logic [1:0]        mem_size,
   input  logic              mem_se,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   mem_access_ctrl_if.master dm,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              misalign,
   output logic              timeout_err,
   output logic              busy
);

   // Counter value seen during the last REQ cycle allowed before abort.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q;
   mem_size_e         size_in, size_q;
   logic [1:0]        off_q;
   logic              se_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic              aligned, accept, finish, tmo_hit;
   logic [31:0]       lane_wdata, ld_ext;

   assign size_in = mem_size_e'(mem_size);
   assign aligned = is_aligned(size_in, addr[1:0]);

   assign dm.dm_req   = (state_q == REQ);
   assign dm.dm_we    = we_q;
   assign dm.dm_addr  = addr_q;
   assign dm.dm_be    = be_q;
   assign dm.dm_wdata = wdata_q;
   assign busy        = (state_q != IDLE);

   mem_lane_align u_lane_align (
      .st_size    (size_in),
      .st_wdata   (wdata),
      .lane_wdata (lane_wdata),
      .ld_size    (size_q),
      .ld_off     (off_q),
      .ld_se      (se_q),
      .ld_rdata   (dm.dm_rdata),
      .ld_data    (ld_ext)
   );

   // State register; reset drops any access in flight at once.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state plus the combinational stall/misalign/accept decodes.
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      misalign = 1'b0;
      accept   = 1'b0;
      finish   = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by reset so stall and misalign read 0 while reset is held.
            if (mem_enable && !reset) begin
               if (aligned) begin
                  state_d = REQ;
                  stall   = 1'b1;
                  accept  = 1'b1;
               end else begin
                  misalign = 1'b1;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            // An ack on the final allowed cycle wins over the timeout.
            if (dm.dm_ack) begin
               state_d = DONE;
               finish  = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               state_d = DONE;
               finish  = 1'b1;
               tmo_hit = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // REQ-cycle counter: runs only while waiting for the ack, zero otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        cnt_q <= '0;
      else if (state_q == REQ && !finish) cnt_q <= cnt_q + 8'd1;
      else                              cnt_q <= '0;
   end

   // Request registers: loaded on acceptance, cleared when the access ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         size_q  <= MEM_BYTE;
         off_q   <= '0;
         se_q    <= 1'b0;
      end else if (accept) begin
         we_q    <= mem_rw;
         addr_q  <= {addr[ADDR_W-1:2], 2'b00};
         be_q    <= lane_be(size_in, addr[1:0]);
         wdata_q <= lane_wdata;
         size_q  <= size_in;
         off_q   <= addr[1:0];
         se_q    <= mem_se;
      end else if (finish) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end
   end

   // Result registers: load data captured on ack, zero for stores and aborts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_data   <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= finish && tmo_hit;
         if (finish) load_data <= (tmo_hit || we_q) ? 32'd0 : ld_ext;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected bus
// requests and results computed from a byte-array memory model; a monitor
// pops and compares them as the controller presents each event.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   localparam int ADDR_W  = 9;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_enable, mem_rw, mem_se;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              stall, misalign, timeout_err, busy;
   logic [31:0]       load_data;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) dm_if ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_enable  (mem_enable),
      .mem_rw      (mem_rw),
      .mem_size    (mem_size),
      .mem_se      (mem_se),
      .addr        (addr),
      .wdata       (wdata),
      .dm          (dm_if),
      .stall       (stall),
      .load_data   (load_data),
      .misalign    (misalign),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic              we;
      logic [31:0]       wdata;
   } bus_exp_t;

   typedef struct {
      logic [31:0] data;
      logic        tmo;
      int          stall_cycles;
   } res_exp_t;

   bus_exp_t    bus_q[$];
   res_exp_t    res_q[$];
   int          mis_q[$];
   logic [7:0]  ref_mem [512];
   logic [31:0] ram [128];
   int          errors = 0;
   int          checks = 0;
   int          ack_delay = 0;
   bit          stray_ack = 1'b0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event without a matching expectation (t=%0t)", name, $time);
   endtask

   function automatic bit model_aligned(input logic [1:0] size, input logic [ADDR_W-1:0] a);
      case (size)
         2'd0:    return 1'b1;
         2'd1:    return a[0] == 1'b0;
         2'd2:    return a[1:0] == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   task automatic preload(input int word_idx, input logic [31:0] val);
      ram[word_idx] = val;
      for (int k = 0; k < 4; k++) ref_mem[4*word_idx + k] = val[31-8*k -: 8];
   endtask

   // Data RAM: acks the delay-th REQ cycle (0 = never), writes/reads by lane.
   initial begin : ram_responder
      int req_cycles;
      int widx;
      req_cycles = 0;
      dm_if.dm_ack   = 1'b0;
      dm_if.dm_rdata = '0;
      forever begin
         @(negedge clk);
         dm_if.dm_ack   = 1'b0;
         dm_if.dm_rdata = $urandom;
         if (dm_if.dm_req) begin
            req_cycles++;
            if (ack_delay != 0 && req_cycles == ack_delay) begin
               dm_if.dm_ack = 1'b1;
               widx = int'(dm_if.dm_addr[ADDR_W-1:2]);
               if (dm_if.dm_we) begin
                  for (int i = 0; i < 4; i++)
                     if (dm_if.dm_be[3-i]) ram[widx][31-8*i -: 8] = dm_if.dm_wdata[31-8*i -: 8];
               end else begin
                  dm_if.dm_rdata = ram[widx];
               end
            end
         end else begin
            req_cycles = 0;
            if (stray_ack) begin
               dm_if.dm_ack = 1'b1;
               stray_ack    = 1'b0;
            end
         end
      end
   end

   // Monitor: compares each bus request, misalign pulse and completion.
   initial begin : monitor
      bit       req_prev;
      int       stall_cnt;
      bus_exp_t b;
      res_exp_t r;
      req_prev  = 1'b0;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            req_prev  = 1'b0;
            stall_cnt = 0;
            continue;
         end
         if (stall) stall_cnt++;
         if (dm_if.dm_req && !req_prev) begin
            if (bus_q.size() == 0) fail_event("dm_req");
            else begin
               b = bus_q.pop_front();
               check("dm_addr", 32'(dm_if.dm_addr), 32'(b.addr));
               check("dm_be", 32'(dm_if.dm_be), 32'(b.be));
               check("dm_we", 32'(dm_if.dm_we), 32'(b.we));
               if (b.we) check("dm_wdata", dm_if.dm_wdata, b.wdata);
            end
         end
         req_prev = dm_if.dm_req;
         if (misalign) begin
            if (mis_q.size() == 0) fail_event("misalign");
            else begin
               void'(mis_q.pop_front());
               check("misalign_stall", 32'(stall), 32'd0);
               check("misalign_req", 32'(dm_if.dm_req), 32'd0);
            end
         end
         if (busy && !stall) begin
            if (res_q.size() == 0) fail_event("done");
            else begin
               r = res_q.pop_front();
               check("load_data", load_data, r.data);
               check("timeout_err", 32'(timeout_err), 32'(r.tmo));
               check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cycles));
               check("done_req_low", 32'(dm_if.dm_req), 32'd0);
            end
            stall_cnt = 0;
         end
      end
   end

   // Issue one access from an IDLE cycle; returns in the next IDLE cycle.
   task automatic do_access(input logic rw, input logic [1:0] size, input logic se,
                            input logic [ADDR_W-1:0] a, input logic [31:0] wd, input int delay);
      bus_exp_t    b;
      res_exp_t    r;
      int          n;
      int          cyc;
      bit          tmo;
      logic [31:0] v;
      n = 1 << size;
      if (!model_aligned(size, a)) begin
         mis_q.push_back(int'(a));
      end else begin
         tmo = (delay == 0) || (delay > TIMEOUT);
         b.addr      = a;
         b.addr[1:0] = 2'b00;
         b.be        = 4'b0000;
         for (int k = 0; k < n; k++) b.be[3 - (int'(a[1:0]) + k)] = 1'b1;
         b.we = rw;
         for (int i = 0; i < 4; i++) b.wdata[31-8*i -: 8] = wd[8*(n-1-(i % n)) +: 8];
         v = 32'd0;
         if (!rw && !tmo) begin
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[int'(a) + k]);
            if (n < 4 && se && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         end
         if (rw && !tmo)
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*(n-1-k) +: 8];
         r.data         = v;
         r.tmo          = tmo;
         r.stall_cycles = tmo ? TIMEOUT + 1 : delay + 1;
         bus_q.push_back(b);
         res_q.push_back(r);
      end
      mem_enable = 1'b1;
      mem_rw     = rw;
      mem_size   = size;
      mem_se     = se;
      addr       = a;
      wdata      = wd;
      ack_delay  = delay;
      if (!model_aligned(size, a)) begin
         @(posedge clk); #1;
         mem_enable = 1'b0;
         return;
      end
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (stall && cyc < 100);
      if (cyc >= 100) fail_event("wait_done_timeout");
      mem_enable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [1:0] sz;
      int         d;
      for (int w = 0; w < 128; w++) preload(w, $urandom);
      reset      = 1'b1;
      mem_enable = 1'b1;
      mem_rw     = 1'b0;
      mem_size   = 2'b10;
      mem_se     = 1'b0;
      addr       = 9'h010;
      wdata      = '0;
      #12;
      check("rst_dm_req", 32'(dm_if.dm_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_dm_be", 32'(dm_if.dm_be), 32'd0);
      check("rst_dm_we", 32'(dm_if.dm_we), 32'd0);
      mem_enable = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      preload(9'h010 >> 2, 32'hDEAD_BEEF);
      do_access(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 3);
      preload(9'h010 >> 2, 32'h0000_00F0);
      do_access(1'b0, 2'b00, 1'b1, 9'h013, 32'd0, 2);
      do_access(1'b0, 2'b00, 1'b0, 9'h013, 32'd0, 1);
      do_access(1'b1, 2'b01, 1'b0, 9'h006, 32'h0000_1234, 2);
      do_access(1'b0, 2'b01, 1'b1, 9'h006, 32'd0, 1);
      do_access(1'b0, 2'b10, 1'b0, 9'h00A, 32'd0, 1);
      do_access(1'b0, 2'b01, 1'b0, 9'h005, 32'd0, 1);
      do_access(1'b1, 2'b11, 1'b0, 9'h008, 32'hFFFF_FFFF, 1);
      do_access(1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 0);
      check("idle_after_timeout", 32'(busy), 32'd0);
      do_access(1'b0, 2'b01, 1'b1, 9'h022, 32'd0, TIMEOUT);
      do_access(1'b1, 2'b10, 1'b0, 9'h024, 32'hCAFE_F00D, TIMEOUT + 1);
      do_access(1'b0, 2'b10, 1'b0, 9'h024, 32'd0, 1);

      // A stray ack while idle must not start anything.
      stray_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("stray_ack_idle", 32'(busy), 32'd0);

      // Randomized accesses, mixing back-to-back and gapped issue.
      for (int t = 0; t < 150; t++) begin
         sz = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       d = 0;
            1:       d = TIMEOUT;
            2:       d = TIMEOUT + 1;
            default: d = $urandom_range(1, 4);
         endcase
         do_access(1'($urandom), sz, 1'($urandom), ADDR_W'($urandom), $urandom, d);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      @(negedge clk);
      check("bus_q_empty", 32'(bus_q.size()), 32'd0);
      check("res_q_empty", 32'(res_q.size()), 32'd0);
      check("mis_q_empty", 32'(mis_q.size()), 32'd0);

      // Reset in the middle of a request aborts it asynchronously.
      mon_en     = 1'b0;
      @(posedge clk); #1;
      ack_delay  = 0;
      mem_enable = 1'b1;
      mem_rw     = 1'b0;
      mem_size   = 2'b10;
      addr       = 9'h040;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      check("midreq_busy", 32'(busy), 32'd1);
      check("midreq_dm_req", 32'(dm_if.dm_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_dm_req", 32'(dm_if.dm_req), 32'd0);
      check("async_rst_stall", 32'(stall), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      mem_enable = 1'b0;
      reset      = 1'b0;
      @(posedge clk); #1;
      check("post_rst_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
